// File: rtl/cache_miss_handler_pkg.sv
// Shared definitions for the cache miss handler and the cache it drives.
// Holds the default data/address widths, the default memory timeout, the
// controller state encoding and a counter-width helper.
package cache_miss_handler_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_SIZE  = 32;
    localparam int DEF_TIMEOUT    = 255;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_FILL   = 3'd3,
        ST_MEM_WR = 3'd4,
        ST_DONE   = 3'd5
    } cmh_state_e;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cache_miss_handler_bus_timeout_counter.sv
// bus_timeout_counter: counts memory wait cycles for the miss handler.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   i_clear     - restart the count at 0 (wins over i_enable)
//   i_enable    - count this cycle (a cycle spent waiting without ack)
//   o_expired   - the current waiting cycle is the TIMEOUT-th one
module bus_timeout_counter
    import cache_miss_handler_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] r_count;

    // Count is 0 during the first wait cycle, so reaching TIMEOUT-1 means
    // this is the last cycle the memory is allowed before giving up.
    assign o_expired = (r_count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      r_count <= '0;
        else if (i_clear)               r_count <= '0;
        else if (i_enable && !o_expired) r_count <= r_count + 1'b1;
    end

endmodule

// File: rtl/cache_miss_handler.sv
// cache_miss_handler: single-outstanding-request controller between a CPU,
// a registered cache and a memory bus. Reads look up the cache and on a miss
// fetch from memory and fill the cache; writes are write-through allocate.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata - CPU request, held until cpu_valid
//   cpu_rdata/cpu_valid/stall   - read result, completion pulse, pipeline hold
//   cache_rd_en/cache_addr      - cache lookup (result on cache_hit/cache_data
//                                 one cycle later)
//   fill_we/fill_data           - cache write port
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata - memory bus
//   bus_err                     - sticky memory timeout flag
module cache_miss_handler
    import cache_miss_handler_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [ADDR_SIZE-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_valid,
    output logic                  stall,
    output logic                  cache_rd_en,
    output logic [ADDR_SIZE-1:0]  cache_addr,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_data,
    output logic                  fill_we,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  bus_err
);
    cmh_state_e            r_state;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_fill_data;
    logic                  r_fill_we;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic                  r_cpu_valid;
    logic                  r_bus_err;

    logic w_in_mem;
    logic w_rd_accept;
    logic w_cnt_clear;
    logic w_cnt_en;
    logic w_expired;

    assign w_in_mem    = (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
    // Write wins over a simultaneous read.
    assign w_rd_accept = !reset && (r_state == ST_IDLE) && cpu_rd && !cpu_wr;
    assign w_cnt_clear = ((r_state == ST_IDLE) && cpu_wr) ||
                         ((r_state == ST_LOOKUP) && !cache_hit);
    assign w_cnt_en    = w_in_mem && !mem_ack;

    bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_en),
        .o_expired (w_expired)
    );

    // Combinational outputs are gated with reset so they drop immediately,
    // even while a request is still being held on the CPU side.
    assign stall       = !reset && ((r_state == ST_IDLE) ? (cpu_rd | cpu_wr)
                                                         : (r_state != ST_DONE));
    assign cache_rd_en = w_rd_accept;
    // The lookup happens in the accepting cycle, before the address is latched.
    assign cache_addr  = reset ? '0 : (w_rd_accept ? cpu_addr : r_addr);

    assign cpu_rdata = r_rdata;
    assign cpu_valid = r_cpu_valid;
    assign fill_we   = r_fill_we;
    assign fill_data = r_fill_data;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign bus_err   = r_bus_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_fill_data <= '0;
            r_fill_we   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_cpu_valid <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_fill_we   <= 1'b0;
            r_cpu_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_wr) begin
                        // Write-through allocate: cache write and memory write
                        // both start from the latched address/data.
                        r_addr      <= cpu_addr;
                        r_wdata     <= cpu_wdata;
                        r_fill_data <= cpu_wdata;
                        r_fill_we   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_state     <= ST_MEM_WR;
                    end else if (cpu_rd) begin
                        r_addr   <= cpu_addr;
                        r_mem_we <= 1'b0;
                        r_state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (cache_hit) begin
                        r_rdata     <= cache_data;
                        r_cpu_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_mem_req <= 1'b1;
                        r_state   <= ST_MEM_RD;
                    end
                end
                ST_MEM_RD, ST_MEM_WR: begin
                    // Ack is checked first so an ack on the last allowed
                    // cycle still completes normally.
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_state == ST_MEM_RD) begin
                            r_rdata     <= mem_rdata;
                            r_fill_data <= mem_rdata;
                            r_fill_we   <= 1'b1;
                            r_state     <= ST_FILL;
                        end else begin
                            r_cpu_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end else if (w_expired) begin
                        r_mem_req   <= 1'b0;
                        r_bus_err   <= 1'b1;
                        r_rdata     <= '0;
                        r_cpu_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_FILL: begin
                    r_cpu_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Bench for cache_miss_handler: a registered cache model plus a vector table
// of CPU transactions with hand-computed expectations, followed by directed
// sequences for timeout, stray ack, and reset during a memory read.
module tb_cache_miss_handler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_valid, stall, cache_rd_en;
    logic [31:0] cache_addr;
    logic        cache_hit = 1'b0;
    logic [31:0] cache_data = '0;
    logic        fill_we;
    logic [31:0] fill_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_miss_handler #(.DATA_WIDTH(32), .ADDR_SIZE(32), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .stall(stall),
        .cache_rd_en(cache_rd_en), .cache_addr(cache_addr),
        .cache_hit(cache_hit), .cache_data(cache_data),
        .fill_we(fill_we), .fill_data(fill_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    // Registered cache model: hit/data appear the cycle after cache_rd_en.
    logic [31:0] cmem [logic [31:0]];
    always @(posedge clk) begin
        cache_hit  <= cache_rd_en && cmem.exists(cache_addr);
        cache_data <= cmem.exists(cache_addr) ? cmem[cache_addr] : 32'h0;
        if (fill_we) cmem[cache_addr] = fill_data;
    end

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata;
        int          ack_after;   // mem_req cycle that carries the ack, 0 = never
        logic [31:0] mrd;
        int          lat;         // request cycle = 1 .. cpu_valid cycle
        int          memcyc;
        logic        mwe, rden;
        int          fills;
        logic [31:0] fdata;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        berr;
    } vec_t;

    function automatic vec_t mk(input logic rd, wr, input logic [31:0] addr, wdata,
                                input int ack_after, input logic [31:0] mrd,
                                input int lat, memcyc, input logic mwe, rden,
                                input int fills, input logic [31:0] fdata,
                                input logic chk_rd, input logic [31:0] rdata,
                                input logic berr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.ack_after = ack_after; v.mrd = mrd; v.lat = lat; v.memcyc = memcyc;
        v.mwe = mwe; v.rden = rden; v.fills = fills; v.fdata = fdata;
        v.chk_rd = chk_rd; v.rdata = rdata; v.berr = berr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int cyc = 0, memcyc = 0, fills = 0, stall_bad = 0;
        logic rden = 0, mwe = 0, mwe_bad = 0, addr_bad = 0, done = 0, berr = 0;
        logic [31:0] fdata = '0, rdata = '0;
        @(negedge clk);
        cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
        while (!done && cyc < 600) begin
            #1;
            cyc++;
            if (cache_rd_en) rden = 1;
            if (fill_we) begin fills++; fdata = fill_data; end
            if (mem_req) begin
                memcyc++;
                if (memcyc == 1) mwe = mem_we;
                else if (mem_we !== mwe) mwe_bad = 1;
                if (mem_addr !== v.addr) addr_bad = 1;
                mem_ack   = (v.ack_after != 0) && (memcyc == v.ack_after);
                mem_rdata = v.mrd;
            end else begin
                mem_ack = 0;
            end
            if (cpu_valid) begin
                done  = 1;
                rdata = cpu_rdata;
                berr  = bus_err;
                if (stall !== 1'b0) stall_bad++;
                cpu_rd = 0; cpu_wr = 0;
            end else begin
                if (stall !== 1'b1) stall_bad++;
                @(negedge clk);
            end
        end
        cpu_rd = 0; cpu_wr = 0; mem_ack = 0;
        chk({tag, " completed"}, 32'(done), 32'd1);
        @(negedge clk); #1;
        chk({tag, " valid one pulse"}, 32'(cpu_valid), 32'd0);
        chk({tag, " latency"}, cyc, v.lat);
        chk({tag, " mem_req cycles"}, memcyc, v.memcyc);
        if (memcyc > 0) chk({tag, " mem_we"}, 32'(mwe), 32'(v.mwe));
        chk({tag, " mem_we/addr stable"}, 32'(mwe_bad | addr_bad), 32'd0);
        chk({tag, " cache_rd_en seen"}, 32'(rden), 32'(v.rden));
        chk({tag, " fill pulses"}, fills, v.fills);
        if (fills > 0) chk({tag, " fill_data"}, fdata, v.fdata);
        if (v.chk_rd) chk({tag, " cpu_rdata"}, rdata, v.rdata);
        chk({tag, " bus_err"}, 32'(berr), 32'(v.berr));
        chk({tag, " stall profile"}, stall_bad, 0);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = mk(0,1,32'h40,32'hDEADBEEF,2,0,           4,2,1,0,1,32'hDEADBEEF,0,0,0);
        tbl[1] = mk(1,0,32'h40,0,0,0,                      3,0,0,1,0,0,1,32'hDEADBEEF,0);
        tbl[2] = mk(1,0,32'h80,0,3,32'h12345678,           7,3,0,1,1,32'h12345678,1,32'h12345678,0);
        tbl[3] = mk(1,0,32'h80,0,0,0,                      3,0,0,1,0,0,1,32'h12345678,0);
        tbl[4] = mk(1,1,32'h10,32'hA5A50010,1,0,           3,1,1,0,1,32'hA5A50010,0,0,0);
        tbl[5] = mk(1,0,32'h10,0,0,0,                      3,0,0,1,0,0,1,32'hA5A50010,0);
        tbl[6] = mk(0,1,32'h80,32'h0BADF00D,1,0,           3,1,1,0,1,32'h0BADF00D,0,0,0);
        tbl[7] = mk(1,0,32'h80,0,0,0,                      3,0,0,1,0,0,1,32'h0BADF00D,0);
        tbl[8] = mk(1,0,32'hC0,0,1,32'h55AA55AA,           5,1,0,1,1,32'h55AA55AA,1,32'h55AA55AA,0);
        // Ack on the 255th wait cycle: same cycle the timeout would fire.
        tbl[9] = mk(1,0,32'h100,0,255,32'hCAFE0100,        259,255,0,1,1,32'hCAFE0100,1,32'hCAFE0100,0);

        // Reset state
        #2;
        chk("rst stall", 32'(stall), 0);
        chk("rst cpu_valid", 32'(cpu_valid), 0);
        chk("rst cpu_rdata", cpu_rdata, 0);
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst fill_we", 32'(fill_we), 0);
        chk("rst cache_rd_en", 32'(cache_rd_en), 0);
        chk("rst bus_err", 32'(bus_err), 0);
        @(negedge clk); @(negedge clk);
        reset = 0;

        for (int i = 0; i < 10; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Read miss with no ack ever: timeout after 255 wait cycles.
        apply_vec(mk(1,0,32'h200,0,0,32'hFFFF0000, 258,255,0,1,0,0,1,32'h0,1), "timeout");

        // Stray ack while idle changes nothing.
        @(negedge clk); #1;
        mem_ack = 1; mem_rdata = 32'h77777777;
        @(negedge clk); #1;
        mem_ack = 0;
        chk("idle ack stall", 32'(stall), 0);
        chk("idle ack cpu_valid", 32'(cpu_valid), 0);
        chk("idle ack mem_req", 32'(mem_req), 0);
        chk("idle ack fill_we", 32'(fill_we), 0);
        chk("idle ack cpu_rdata", cpu_rdata, 32'h0);
        chk("idle ack mem_addr", mem_addr, 32'h200);
        chk("idle ack bus_err sticky", 32'(bus_err), 1);
        apply_vec(mk(1,0,32'h40,0,0,0, 3,0,0,1,0,0,1,32'hDEADBEEF,1), "after idle ack");

        // Reset while waiting in MEM_RD.
        begin
            int w = 0;
            @(negedge clk);
            cpu_rd = 1; cpu_addr = 32'h300;
            #1;
            while (!mem_req && w < 10) begin @(negedge clk); #1; w++; end
            chk("midrst mem_req reached", 32'(mem_req), 1);
            @(negedge clk); @(negedge clk); #1;
            reset = 1;
            #1;
            chk("midrst mem_req", 32'(mem_req), 0);
            chk("midrst stall", 32'(stall), 0);
            chk("midrst cache_rd_en", 32'(cache_rd_en), 0);
            chk("midrst cpu_valid", 32'(cpu_valid), 0);
            chk("midrst mem_addr", mem_addr, 0);
            chk("midrst bus_err cleared", 32'(bus_err), 0);
            cpu_rd = 0;
            @(negedge clk); @(negedge clk);
            reset = 0;
        end
        apply_vec(mk(1,0,32'h40,0,0,0, 3,0,0,1,0,0,1,32'hDEADBEEF,0), "after reset");
        apply_vec(mk(1,0,32'h340,0,2,32'h13579BDF, 6,2,0,1,1,32'h13579BDF,1,32'h13579BDF,0), "miss after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_miss_handler.md
CACHE_MISS_HANDLER -- requirements
Module: cache_miss_handler

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, meaning CPU/cache/memory data width.
REQ-002 The block SHALL take parameter ADDR_SIZE, default 32, meaning byte-address width.
REQ-003 The block SHALL take parameter TIMEOUT, default 255, meaning maximum memory wait cycles before a bus error.
REQ-004 clk  input  1  clock, all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cpu_rd / cpu_wr  input  1 each  CPU read/write request, held until cpu_valid.
REQ-007 cpu_addr / cpu_wdata  input  ADDR_SIZE / DATA_WIDTH  request address and write data.
REQ-008 cpu_rdata  output  DATA_WIDTH  read result; cpu_valid  output  1  one-cycle completion pulse; stall  output  1  pipeline hold.
REQ-009 cache_rd_en  output  1  read_enable to cache; cache_addr  output  ADDR_SIZE  cache address; cache_hit / cache_data  input  1 / DATA_WIDTH  registered cache hit and data.
REQ-010 fill_we  output  1  cache write_enable; fill_data  output  DATA_WIDTH  cache data_in.
REQ-011 mem_req / mem_we  output  1 each  memory request and direction; mem_addr / mem_wdata  output  ADDR_SIZE / DATA_WIDTH; mem_ack / mem_rdata  input  1 / DATA_WIDTH.
REQ-012 bus_err  output  1  sticky timeout flag.

Function
REQ-013 FSM states SHALL be IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, DONE; registered encoding.
REQ-014 In IDLE with cpu_wr=1 the block SHALL latch addr/data, pulse fill_we for one cycle (write-through allocate), go MEM_WR; cpu_wr SHALL take priority when cpu_rd=1 simultaneously.
REQ-015 In IDLE with cpu_rd=1 only, the block SHALL latch addr, assert cache_rd_en that cycle, go LOOKUP.
REQ-016 In LOOKUP, cache_hit=1 SHALL load cpu_rdata<=cache_data and go DONE; cache_hit=0 SHALL go MEM_RD.
REQ-017 In MEM_RD/MEM_WR, mem_req SHALL stay high with stable mem_addr/mem_we/mem_wdata until the cycle mem_ack=1 is sampled; mem_req SHALL drop the following cycle.
REQ-018 MEM_RD on mem_ack SHALL capture mem_rdata and go FILL; FILL SHALL pulse fill_we with fill_data=captured word, cpu_rdata=captured word, then go DONE.
REQ-019 MEM_WR on mem_ack SHALL go DONE.
REQ-020 DONE SHALL last exactly one cycle with cpu_valid=1, stall=0, then IDLE; no new request is accepted in DONE.
REQ-021 stall SHALL be combinational: 1 in IDLE when cpu_rd|cpu_wr, 1 in LOOKUP/MEM_RD/FILL/MEM_WR, 0 in DONE and idle-without-request.
REQ-022 A wait counter SHALL clear on entering MEM_RD/MEM_WR and increment each cycle without mem_ack; reaching TIMEOUT SHALL drop mem_req, set bus_err, set cpu_rdata=0, go DONE.
REQ-023 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-024 mem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-025 Hit latency SHALL be 3 cycles request-to-cpu_valid; miss latency SHALL be 4 + memory wait cycles.

Reset
REQ-026 Reset SHALL force IDLE, counter 0, and all outputs 0 (stall, cpu_valid, cpu_rdata, cache_rd_en, fill_we, mem_req, mem_we, bus_err, addresses, data) immediately, including mid-transaction.
REQ-027 bus_err SHALL clear only on reset.

Structure
REQ-028 State encodings and default widths SHALL live in the shared memories definitions include, reused by the cache.
REQ-029 The wait counter SHALL be one sub-module, bus_timeout_counter (clear, enable, expired).

Verification
REQ-030 Read 0x40 after write 0x40=0xDEADBEEF acked in 2 cycles -> hit, cpu_rdata=0xDEADBEEF, cpu_valid 3 cycles after request, mem_req never high for the read.
REQ-031 Cold read 0x80, mem_rdata=0x12345678 ack after 3 cycles -> fill_we one pulse with 0x12345678, cpu_valid with same data, repeat read hits.
REQ-032 cpu_rd and cpu_wr both high at 0x10 -> write path only, mem_we=1, no cache_rd_en.
REQ-033 Read miss, mem_ack never -> mem_req drops after 255 wait cycles, bus_err=1, cpu_rdata=0, cpu_valid one pulse.
REQ-034 Reset asserted while mem_req=1 in MEM_RD -> mem_req/stall 0 without clock edge, state IDLE, next request served normally.
REQ-035 mem_ack pulsed while IDLE -> no state change, no output change.
